wait_state_ctrl: RTL

WAIT_STATE_CTRL -- requirements
Module: wait_state_ctrl

---
 rtl/wait_state_ctrl_pkg.sv | 20 ++
 rtl/wait_state_ctrl_timer.sv | 29 ++
 rtl/wait_state_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/wait_state_ctrl_pkg.sv
// Shared encodings and constants for the 6809 slow-device wait-state controller.
package wait_state_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // CFG_DATA field layout
  localparam int CFG_REN_BIT = 4;
  localparam int CFG_WS_MSB  = 3;
  localparam int CFG_WS_LSB  = 0;

  localparam int DEF_WS        = 15;
  localparam int DEF_TMO_TICKS = 1023;
  localparam int TMR_W         = 10;

endpackage

// File: rtl/wait_state_ctrl_timer.sv
// Loadable down-counter with zero flag; times both the fixed stretch and the READY hold.
module wait_timer
  import wait_state_ctrl_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/wait_state_ctrl.sv
// Stretches the 6809 E/Q clocks for slow devices: per-slot wait count plus optional READY hold.
//   state   | meaning
//   IDLE    | waiting for Q rise with a slow-device select
//   STRETCH | nWAIT low, counting WS*4 ticks
//   HOLD    | nWAIT low, waiting for READY or timeout
//   DONE    | stretch finished, waiting for E fall
module wait_state_ctrl
  import wait_state_ctrl_pkg::*;
#(
  parameter int NSEL      = 4,
  parameter int WS_W      = 4,
  parameter int TMO_TICKS = DEF_TMO_TICKS
) (
  input  logic            MHZ48,
  input  logic            RESET,
  input  logic            nE,
  input  logic            nQ,
  input  logic [NSEL-1:0] SEL,
  input  logic            READY,
  input  logic            CFG_WE,
  input  logic [1:0]      CFG_ADDR,
  input  logic [4:0]      CFG_DATA,
  output logic            nWAIT,
  output logic            BUSY,
  output logic            TMO
);

  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TMO_TICKS - 1);

  state_t state, state_nxt;

  logic nq_r, nq_r2, ne_r, ne_r2;
  logic q_rise, e_fall;

  logic [WS_W-1:0] ws_tab [NSEL];
  logic [NSEL-1:0] ren_tab;
  logic            cfg_hit;

  logic            hit;
  logic [WS_W-1:0] sel_ws;
  logic            sel_ren;
  logic            ren_lat;
  logic            arm;
  logic            tmo_set;

  logic             tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0] tmr_val, stretch_load;

  // nQ history resets to "Q high" so a bus cycle already in flight at reset cannot arm
  always_ff @(posedge MHZ48) begin
    if (RESET) begin
      nq_r  <= 1'b0;
      nq_r2 <= 1'b0;
      ne_r  <= 1'b1;
      ne_r2 <= 1'b1;
    end else begin
      nq_r  <= nQ;
      nq_r2 <= nq_r;
      ne_r  <= nE;
      ne_r2 <= ne_r;
    end
  end

  assign q_rise = nq_r2 & ~nq_r;
  assign e_fall = ~ne_r2 & ne_r;

  assign cfg_hit = CFG_WE && (int'(CFG_ADDR) < NSEL);

  always_ff @(posedge MHZ48) begin
    if (RESET) begin
      for (int i = 0; i < NSEL; i++) ws_tab[i] <= WS_W'(DEF_WS);
      ren_tab <= '0;
    end else if (cfg_hit) begin
      ws_tab[CFG_ADDR]  <= WS_W'(CFG_DATA[CFG_WS_MSB:CFG_WS_LSB]);
      ren_tab[CFG_ADDR] <= CFG_DATA[CFG_REN_BIT];
    end
  end

  // Lowest set select wins: scan downward so the last match is the lowest index
  always_comb begin
    hit     = 1'b0;
    sel_ws  = '0;
    sel_ren = 1'b0;
    for (int i = NSEL - 1; i >= 0; i--) begin
      if (SEL[i]) begin
        hit     = 1'b1;
        sel_ws  = ws_tab[i];
        sel_ren = ren_tab[i];
      end
    end
  end

  assign stretch_load = TMR_W'({sel_ws, 2'b00}) - TMR_W'(1);

  always_comb begin
    state_nxt = state;
    arm       = 1'b0;
    tmo_set   = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_dec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (q_rise && hit) begin
          arm = 1'b1;
          if (sel_ws != '0) begin
            state_nxt = ST_STRETCH;
            tmr_load  = 1'b1;
            tmr_val   = stretch_load;
          end else if (sel_ren && !READY) begin
            state_nxt = ST_HOLD;
            tmr_load  = 1'b1;
            tmr_val   = TMO_LOAD;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_STRETCH: begin
        if (tmr_zero) begin
          if (ren_lat && !READY) begin
            state_nxt = ST_HOLD;
            tmr_load  = 1'b1;
            tmr_val   = TMO_LOAD;
          end else begin
            state_nxt = ST_DONE;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (READY) begin
          state_nxt = ST_DONE;
        end else if (tmr_zero) begin
          state_nxt = ST_DONE;
          tmo_set   = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_DONE: begin
        if (e_fall) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge MHZ48) begin
    if (RESET) begin
      state   <= ST_IDLE;
      nWAIT   <= 1'b1;
      ren_lat <= 1'b0;
      TMO     <= 1'b0;
    end else begin
      state <= state_nxt;
      nWAIT <= !((state_nxt == ST_STRETCH) || (state_nxt == ST_HOLD));
      if (arm) ren_lat <= sel_ren;
      // A timeout in the same tick as a config write still reports
      if (tmo_set) TMO <= 1'b1;
      else if (CFG_WE) TMO <= 1'b0;
    end
  end

  assign BUSY = (state == ST_STRETCH) || (state == ST_HOLD);

  wait_timer #(.W(TMR_W)) u_timer (
    .clk      (MHZ48),
    .rst      (RESET),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

endmodule
